minmax_queue: RTL

MINMAX_QUEUE -- requirements
Module: minmax_queue

---
 rtl/minmax_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/minmax_queue.sv
// -----------------------------------------------------------------------------
// minmax_queue
//
// Small priority store holding up to DEPTH unsigned elements. Each element
// sits in its own slot. The pop side always shows the largest element
// (MINMAX_=0) or the smallest element (MINMAX_=1) among the valid slots.
// When several valid slots hold the same value, the lowest slot index wins.
// A push writes into the lowest-index free slot. A pop frees the slot that
// is currently selected.
//
// Parameters
//   MINMAX_ : 0 = maximum first, 1 = minimum first
//   DEPTH   : number of slots (>= 2)
//   DATA    : element width in bits
//   OUT     : slot index width (derived)
//   CNT     : occupancy count width (derived)
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-high; clears every slot and the count
//   push_valid : producer offers push_data
//   push_ready : high while the store is not full
//   push_data  : element to insert
//   pop_valid  : high while the store is not empty
//   pop_ready  : consumer takes pop_data this cycle
//   pop_data   : selected element (0 when empty)
//   pop_idx    : slot holding pop_data (0 when empty)
//   count      : number of valid slots
//   full       : count == DEPTH
//   empty      : count == 0
// -----------------------------------------------------------------------------
module minmax_queue #(
  parameter int MINMAX_ = 0,
  parameter int DEPTH   = 8,
  parameter int DATA    = 8,
  parameter int OUT     = $clog2(DEPTH),
  parameter int CNT     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [DATA-1:0] push_data,
  output logic            pop_valid,
  input  logic            pop_ready,
  output logic [DATA-1:0] pop_data,
  output logic [OUT-1:0]  pop_idx,
  output logic [CNT-1:0]  count,
  output logic            full,
  output logic            empty
);

  // Slot storage and occupancy
  logic [DATA-1:0]  slot_data_q [DEPTH];
  logic [DEPTH-1:0] slot_vld_q;
  logic [DEPTH-1:0] slot_vld_d;
  logic [CNT-1:0]   count_q;
  logic [CNT-1:0]   count_d;

  // Selection results and free-slot search
  logic            sel_found;
  logic [DATA-1:0] sel_data;
  logic [OUT-1:0]  sel_idx;
  logic [OUT-1:0]  free_idx;

  logic push_fire;
  logic pop_fire;

  // True when candidate a should replace the current best b. The comparison
  // is strict, so an equal value found later never displaces an earlier
  // (lower-index) slot. This gives lowest-index tie resolution.
  function automatic logic better(input logic [DATA-1:0] a,
                                  input logic [DATA-1:0] b);
    if (MINMAX_ == 0) begin
      better = (a > b);
    end else begin
      better = (a < b);
    end
  endfunction

  // Status flags depend only on registered state. Because of this,
  // push_ready has no path from pop_ready.
  assign full       = (count_q == CNT'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_ready = ~full;
  assign pop_valid  = ~empty;

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;

  // Combinational selection over valid slots only. An invalid slot never
  // takes part, so its stale contents cannot win.
  always_comb begin
    sel_found = 1'b0;
    sel_data  = '0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld_q[i] && (!sel_found || better(slot_data_q[i], sel_data))) begin
        sel_found = 1'b1;
        sel_data  = slot_data_q[i];
        sel_idx   = OUT'(i);
      end
    end
  end

  assign pop_data = sel_data;
  assign pop_idx  = sel_idx;

  // Lowest-index free slot. The scan runs from the top down, so the last hit
  // is the lowest index. The result is only used when push_fire is set, and
  // push_fire implies at least one free slot.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld_q[i]) begin
        free_idx = OUT'(i);
      end
    end
  end

  // Next valid vector. Both the free slot and the popped slot come from
  // pre-edge state. A push needs a free slot and a pop needs a valid one,
  // so the two can never name the same slot.
  always_comb begin
    slot_vld_d = slot_vld_q;
    if (pop_fire) begin
      slot_vld_d[sel_idx] = 1'b0;
    end
    if (push_fire) begin
      slot_vld_d[free_idx] = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      count_q    <= count_d;
      if (push_fire) begin
        slot_data_q[free_idx] <= push_data;
      end
    end
  end

endmodule
